// File: rtl/key_entry_if.sv
// Word hand-off bus between key_entry (master) and the control unit (slave).
interface key_entry_if #(
  parameter int DIGITS = 4
) ();
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  // Handshake: the master raises word_valid with word_data stable and holds both
  // until a rising clk edge sees word_valid && word_ready; that edge completes the
  // transfer. word_ready while word_valid is low has no effect.
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] digit_cnt;

  modport master (
    output word_data,
    output word_valid,
    output digit_cnt,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    input  digit_cnt,
    output word_ready
  );
endinterface

// File: rtl/key_entry.sv
// Keypad digit capture: syncs KP/KB, queues one digit per keypress, assembles words.
// Optional sticky overflow flag key_ovf enabled by defining KEY_ENTRY_OVF_EN.
module key_entry #(
  parameter int DIGITS     = 4,
  parameter int SETTLE     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        KP,
  input  logic [3:0]  KB,
  input  logic        clr,
  key_entry_if.master kbus,
`ifdef KEY_ENTRY_OVF_EN
  output logic        key_ovf,
`endif
  output logic        dbg_state
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]    SETTLE_LD = 4'(SETTLE);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DIGITS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } cap_state_e;

  logic       kp_meta, kp_s, kp_d;
  logic [3:0] kb_meta, kb_s;
  logic       kp_evt;

  cap_state_e state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic       push;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic          pop, push_ok;

  logic [W-1:0]  word_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;

  // Synchronisers are deliberately untouched by clr so clearing never fakes an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_meta <= 1'b0;
      kp_s    <= 1'b0;
      kp_d    <= 1'b0;
      kb_meta <= 4'h0;
      kb_s    <= 4'h0;
    end else begin
      kp_meta <= KP;
      kp_s    <= kp_meta;
      kp_d    <= kp_s;
      kb_meta <= KB;
      kb_s    <= kb_meta;
    end
  end

  assign kp_evt = kp_s ^ kp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= 4'h0;
    end else if (clr) begin
      state_q  <= S_IDLE;
      settle_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Events seen while waiting are dropped: keypad frames are far apart.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (kp_evt) begin
          state_d  = S_WAIT;
          settle_d = SETTLE_LD;
        end
      end
      S_WAIT: begin
        if (settle_q == 4'h0) state_d = S_IDLE;
        else                  settle_d = settle_q - 4'h1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push      = (state_q == S_WAIT) && (settle_q == 4'h0);
    dbg_state = (state_q == S_WAIT);
  end

  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && !valid_q;
  // A full FIFO still takes the digit when a slot frees up in the same cycle.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= kb_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (clr) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (valid_q && kbus.word_ready) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      word_q <= {word_q[W-5:0], mem[rd_ptr]};
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) valid_q <= 1'b1;
    end
  end

`ifdef KEY_ENTRY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      key_ovf <= 1'b0;
    else if (clr)                    key_ovf <= 1'b0;
    else if (push && fifo_full && !pop) key_ovf <= 1'b1;
  end
`endif

  assign kbus.word_data  = word_q;
  assign kbus.word_valid = valid_q;
  assign kbus.digit_cnt  = cnt_q;
endmodule

// File: doc/key_entry.md
# key_entry

Downstream consumer of the PS/2 keypad decoder. It takes the decoder's toggle-per-keypress strobe `KP` and hex key code `KB`, which are asynchronous to the system clock, and synchronises both into the system clock domain. Each keypress becomes one 4-bit digit, which is queued in a small FIFO. Digits are assembled MSB-first into a `DIGITS`-nibble word, and the finished word is handed to the control unit over a valid/ready handshake.

## Interface
- `DIGITS`, 4: hex digits per assembled word (2..8).
- `SETTLE`, 4: system clocks waited after a detected `KP` toggle before sampling `KB` (1..15).
- `FIFO_DEPTH`, 4: digit FIFO entries (power of two, 2..16).

- `clk` input 1: system clock; all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `KP` input 1: keypress strobe from the keypad decoder, asynchronous. Every level change (either direction) is one keypress.
- `KB` input 4: hex key code from the keypad decoder, asynchronous, stable long before/after `KP` changes.
- `clr` input 1: synchronous clear of FIFO, word, count, valid (and overflow flag).
- `word_data` output 4*DIGITS: assembled word, first key entered in the MSB nibble.
- `word_valid` output 1: word complete, held until accepted.
- `word_ready` input 1: control unit accepts the word.
- `digit_cnt` output $clog2(DIGITS+1): digits currently in `word_data`.
- `key_ovf` output 1: sticky FIFO overflow; present only with `KEY_ENTRY_OVF_EN`.

## Operation
- Sync:
  - `KP` passes through 2 flops to give `kp_s`, with a third flop `kp_d`.
  - An event is flagged in cycle E when `kp_s != kp_d`.
  - `KB` passes through 2 flops to give `kb_s`.
- Capture FSM:
  - In `IDLE`, an event loads the settle counter with `SETTLE` and moves to `WAIT`.
  - `WAIT` decrements the counter. At 0 it pushes `kb_s` into the FIFO and returns to `IDLE`.
  - Events arriving during `WAIT` are ignored, since PS/2 frames are about 1 ms apart.
- FIFO:
  - Write pointer, read pointer and count are registered.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the digit is dropped.
  - A pop when empty is impossible by construction.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Assembler:
  - Pops one digit per cycle while the FIFO is non-empty and `word_valid`=0.
  - On each pop: `word_data <= {word_data[4*DIGITS-5:0], digit}` and `digit_cnt` increments.
  - When `digit_cnt` reaches `DIGITS` on a pop, `word_valid` rises in the same update.
- Handshake:
  - `word_valid` && `word_ready` at a rising edge clears `word_valid`, `word_data` and `digit_cnt` to 0 on that edge.
  - `word_ready` without `word_valid` has no effect.
  - `word_data` is stable while `word_valid`=1.
- Back-pressure: while `word_valid`=1 no pops occur, so keys accumulate in the FIFO up to `FIFO_DEPTH`.
- `clr`:
  - Highest priority. Next edge: FIFO empty, pointers 0, `word_data`=0, `digit_cnt`=0, `word_valid`=0, capture FSM to `IDLE`, `key_ovf`=0.
  - `kp_s`/`kp_d` are not cleared, so no spurious event is created.
- Reset values:
  - All outputs 0, FSM `IDLE`, FIFO empty.
  - Sync flops reset to 0. If `KP`=1 at reset release, one spurious event is raised; the control unit must issue `clr` after reset.

## Timing
- Event E is detected 2–3 clocks after the `KP` edge, depending on synchroniser phase.
- The FIFO push occurs at edge E+SETTLE+1.
- With an empty FIFO and `word_valid`=0, the digit appears in `word_data` and `digit_cnt` at edge E+SETTLE+2.
- `word_valid` is asserted at the same edge the `DIGITS`th digit is shifted in.
- Throughput: 1 digit/clock from the FIFO; keypad rate is far lower.
- Reset mid-operation: asynchronous, all state to reset values immediately; a partial word is lost.

## Configuration
- `KEY_ENTRY_OVF_EN` defined:
  - `key_ovf` port exists.
  - It sets at the edge a push is dropped because the FIFO is full and no pop happens that cycle.
  - It clears only on `clr` or reset.
- Undefined: no port and no flag logic. Dropped digits are silently discarded.

## Test plan
- Reset, `clr`; toggle `KP` four times with `KB`=1,2,3,4 → `word_valid`=1, `word_data`=16'h1234, `digit_cnt`=4; pulse `word_ready` → next edge valid=0, data=0, cnt=0.
- Single toggle with `KB`=4'hA, count clocks from the `KP` edge → `digit_cnt`=1 and `word_data`=16'h000A, no earlier than SETTLE+4 clocks and no later than SETTLE+5 clocks after the `KP` edge.
- Hold `word_ready`=0 after word 16'h1234, enter keys 5,6,7,8 → `word_data` unchanged; raise `word_ready` → next word 16'h5678 valid 4 clocks later.
- With word pending and `FIFO_DEPTH`=4, enter 5 keys → 5th dropped; with macro, `key_ovf`=1; `clr` → `key_ovf`=0, `digit_cnt`=0, `word_valid`=0.
- `clr` asserted during `WAIT` after 2 digits entered → no push occurs, `digit_cnt`=0; the next keypress gives `word_data`=that digit only.
- Assert `rst_n`=0 mid-word (`digit_cnt`=3) → all outputs 0 immediately; resume entry → new word formed from fresh digits.
